// File: rtl/mips_step_controller.sv
// mips_step_controller: five-phase multi-cycle sequencer with run/step/halt control for the MIPS datapath
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   run, step, halt_req   host controls: continuous run, single instruction, stop after retire
//   opcode, branch_taken  Instruction[31:26] and Branch&Zero from the datapath
//   pc_we, ir_we          registered PC load and instruction latch enables
//   reg_we_en, mem_we_en  registered gates for RegWrite and MemWrite
//   phase, busy, halted   current state, FETCH..WB indicator, HALT indicator
//   instr_count           retired-instruction counter (wraps)
// Optional: define MIPS_CTRL_BRANCH_CNT_EN to add branch_count[15:0], counting taken branches at retire.
module mips_step_controller #(
    parameter int         PHASE_CYCLES = 1,
    parameter int         CNT_W        = 32,
    parameter logic [5:0] HALT_OPCODE  = 6'b111111,
    parameter logic [5:0] LW_OPCODE    = 6'b100011,
    parameter logic [5:0] SW_OPCODE    = 6'b101011
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             step,
    input  logic             halt_req,
    input  logic [5:0]       opcode,
    input  logic             branch_taken,
    output logic             pc_we,
    output logic             ir_we,
    output logic             reg_we_en,
    output logic             mem_we_en,
    output logic [2:0]       phase,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
`ifdef MIPS_CTRL_BRANCH_CNT_EN
    ,
    output logic [15:0]      branch_count
`endif
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;
    localparam logic [7:0] LAST     = 8'(PHASE_CYCLES - 1);
    logic [2:0]       r_state, w_next;
    logic [7:0]       r_dwell, w_dwell;
    logic             r_run_mode, r_ir_we, r_pc_we, r_mem_we;
    logic [CNT_W-1:0] r_instr_count;
    logic             w_last, w_active, w_nlast, w_retire;
    assign w_last   = r_dwell == LAST;
    assign w_active = (r_state != S_IDLE) && (r_state < S_HALT);
    assign w_retire = (r_state == S_WB) && w_last;
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:   w_next = (run || step) ? S_FETCH : S_IDLE;
            S_FETCH:  w_next = w_last ? S_DECODE : S_FETCH;
            S_DECODE: w_next = w_last ? S_EXEC : S_DECODE;
            S_EXEC:   w_next = !w_last ? S_EXEC : (opcode == LW_OPCODE || opcode == SW_OPCODE) ? S_MEM : S_WB;
            S_MEM:    w_next = w_last ? S_WB : S_MEM;
            S_WB:     w_next = !w_last ? S_WB : (halt_req || opcode == HALT_OPCODE) ? S_HALT :
                               (r_run_mode && run) ? S_FETCH : S_IDLE;
            S_HALT:   w_next = (!run && !step && !halt_req) ? S_IDLE : S_HALT;
            default:  w_next = S_IDLE;
        endcase
    end
    // Every transition lands in a different state, so a state change is a phase entry.
    assign w_dwell = (w_next != r_state || !w_active) ? 8'd0 : r_dwell + 8'd1;
    assign w_nlast = w_dwell == LAST;
    // Strobes are computed from the next state so they are glitch-free register outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_dwell       <= 8'd0;
            r_run_mode    <= 1'b0;
            r_ir_we       <= 1'b0;
            r_pc_we       <= 1'b0;
            r_mem_we      <= 1'b0;
            r_instr_count <= '0;
        end else begin
            r_state  <= w_next;
            r_dwell  <= w_dwell;
            r_ir_we  <= (w_next == S_FETCH) && w_nlast;
            r_mem_we <= (w_next == S_MEM) && w_nlast;
            r_pc_we  <= (w_next == S_WB) && w_nlast;
            if (r_state == S_IDLE && w_next == S_FETCH)
                r_run_mode <= run;
            if (w_retire)
                r_instr_count <= r_instr_count + CNT_W'(1);
        end
    end
`ifdef MIPS_CTRL_BRANCH_CNT_EN
    logic [15:0] r_branch_count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_branch_count <= 16'd0;
        else if (w_retire && branch_taken)
            r_branch_count <= r_branch_count + 16'd1;
    end
    assign branch_count = r_branch_count;
`else
    logic w_unused_branch;
    assign w_unused_branch = branch_taken;
`endif
    assign phase       = r_state;
    assign busy        = w_active;
    assign halted      = r_state == S_HALT;
    assign ir_we       = r_ir_we;
    assign pc_we       = r_pc_we;
    assign reg_we_en   = r_pc_we;
    assign mem_we_en   = r_mem_we;
    assign instr_count = r_instr_count;
endmodule

// File: doc/mips_step_controller.md
Name: mips_step_controller

Overview:
Multi-cycle sequencer for the 32-bit MIPS computer. It replaces the free-running clock divider with an explicit phase FSM: FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK. It gates the PC, instruction-register, register-file and data-memory write strobes. It adds run, single-step and halt control so a host or bench can start, stop and step the datapath one instruction at a time.

Parameters:
PHASE_CYCLES, 1, clock cycles spent in each active phase (1..255)
CNT_W, 32, width of the retired-instruction counter
HALT_OPCODE, 6'b111111, opcode that halts the machine after it retires
LW_OPCODE, 6'b100011, load opcode (needs the MEMORY phase)
SW_OPCODE, 6'b101011, store opcode (needs the MEMORY phase)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
run  input  1  level; continuous execution while high
step  input  1  level; sampled in IDLE; executes exactly one instruction
halt_req  input  1  level; stop after the current instruction retires
opcode  input  6  Instruction[31:26] from instruction memory
branch_taken  input  1  Branch AND Zero from the datapath
pc_we  output  1  PC register load enable
ir_we  output  1  instruction latch enable
reg_we_en  output  1  gate ANDed with control RegWrite
mem_we_en  output  1  gate ANDed with control MemWrite
phase  output  3  current state encoding
busy  output  1  high in FETCH..WB
halted  output  1  high in HALT
instr_count  output  CNT_W  retired-instruction count

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state IDLE (phase=0)
  - all strobes 0, busy 0, halted 0
  - instr_count 0
  - dwell counter 0, run_mode 0
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Value 7 is unreachable; if it occurs, go to IDLE on the next edge.
- Dwell counter:
  - Each active phase lasts exactly PHASE_CYCLES cycles.
  - The counter clears on every phase entry.
  - "Last cycle" means dwell == PHASE_CYCLES-1.
- IDLE:
  - run=1 -> FETCH with run_mode=1.
  - Else step=1 -> FETCH with run_mode=0.
  - run has priority when run and step are high together.
- FETCH -> DECODE. ir_we=1 on the last cycle only.
- DECODE -> EXEC.
- EXEC:
  - opcode is LW_OPCODE or SW_OPCODE -> MEM.
  - Otherwise -> WB; MEM is skipped.
- MEM -> WB. mem_we_en=1 on the last cycle only.
- WB, last cycle:
  - reg_we_en=1 and pc_we=1 (one cycle each).
  - instr_count increments; wraps from all-ones to 0.
- Next state after WB:
  - halt_req=1 or opcode==HALT_OPCODE -> HALT.
  - Else run_mode=1 and run=1 -> FETCH.
  - Else -> IDLE.
- HALT: halted=1. Returns to IDLE only when run, step and halt_req are all 0.
- Mid-instruction inputs:
  - Deasserting run does not abort the current instruction; it completes through WB.
  - halt_req asserted mid-instruction is honoured at the end of WB.
- Strobe rules:
  - Strobes are registered (Moore) outputs.
  - At most one of ir_we, mem_we_en and pc_we is high in any cycle.
  - reg_we_en and pc_we are high together.
- branch_taken is not interpreted by the FSM; the datapath PC mux uses it.
- Latency at PHASE_CYCLES=1:
  - Non-memory instruction: 4 cycles from FETCH entry to pc_we.
  - lw or sw: 5 cycles.
  - Back-to-back instructions in run mode have no bubble: WB -> FETCH.
- rst_n falling in any state immediately forces the reset values, with no write strobe glitch.

Optional Feature:
MIPS_CTRL_BRANCH_CNT_EN
- Defined:
  - Adds output port branch_count [15:0], reset to 0.
  - It increments (with wrap) in the cycle pc_we=1 while branch_taken=1.
- Undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, release -> phase=0, all strobes 0, instr_count=0, busy=0.
- Single step: opcode=0 (R-type), step pulsed for 1 cycle, PHASE_CYCLES=1 -> phases 1,2,3,5. ir_we in cycle 1, pc_we and reg_we_en in cycle 4. Then IDLE, instr_count=1. No mem_we_en.
- Load: opcode=6'b100011, step -> phases 1,2,3,4,5. mem_we_en in cycle 4, pc_we in cycle 5, instr_count=1.
- Run and halt: run=1 with opcode=0 for 3 instructions -> pc_we every 4 cycles, with no IDLE between instructions. halt_req raised during EXEC of the 3rd instruction -> WB completes, instr_count=3, then HALT with halted=1. Dropping all inputs -> IDLE.
- HALT opcode and priority: run=1, opcode=6'b111111 -> one instruction retires, then HALT. Separately, run=1 and step=1 together in IDLE -> run_mode=1, continuous execution.
- Wrap and async reset, with PHASE_CYCLES=3 and CNT_W=4:
  - Each phase lasts 3 cycles.
  - instr_count goes 15 -> 0 on the 16th retire.
  - rst_n=0 asserted during MEM -> outputs clear immediately, mem_we_en is never pulsed.
  - With MIPS_CTRL_BRANCH_CNT_EN defined and branch_taken=1 during 2 retires, branch_count=2.
